// File: rtl/stopwatch_display_if.sv
// Bus between the stopwatch counter path and the MM.SS display driver.
// The counter side drives time and adjust controls; the display side returns the panel drives.
interface stopwatch_display_if;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adj;
  logic       sel;
  logic       blink_clk;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output minutes, seconds, adj, sel, blink_clk,
    input  seg, dp, an
  );

  modport slave (
    input  minutes, seconds, adj, sel, blink_clk,
    output seg, dp, an
  );
endinterface

// File: rtl/stopwatch_display.sv
// 4-digit multiplexed common-anode MM.SS display driver with per-frame snapshot and BCD split.
// Define ADJ_BLINK_EN to blank the field under adjustment while blink_clk is high.
module stopwatch_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic                clk,
  input logic                rst_n,
  stopwatch_display_if.slave bus
);
  localparam int unsigned    DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_OFF  = 7'h7F;
  localparam logic [6:0]     SEG_DASH = 7'b0111111;

  // Tens in [7:4], ones in [3:0]; values above 59 are never rendered, so their split is don't-care.
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    if      (v >= 6'd50) t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    r = v - ({2'b00, t} * 6'd10);
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick_p0;
  logic [1:0]       idx;
  logic [5:0]       min_s;
  logic [5:0]       sec_s;
  logic             blink_q;
  logic             vld_p1;
  logic [6:0]       seg_p2;
  logic             dp_p2;
  logic [3:0]       an_p2;

  logic [5:0]       field_v;
  logic [7:0]       digits;
  logic [3:0]       digit;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [3:0]       an_nxt;
  logic             blank_nxt;

  assign tick_p0 = (div_cnt == DIV_LAST);

  // Stage 0 -> 1: refresh divider, slot index, frame-end snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      min_s   <= 6'd0;
      sec_s   <= 6'd0;
      blink_q <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      blink_q <= bus.blink_clk;
      vld_p1  <= tick_p0;
      div_cnt <= tick_p0 ? '0 : div_cnt + DIV_W'(1);
      if (tick_p0) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          min_s <= bus.minutes;
          sec_s <= bus.seconds;
        end
      end
    end
  end

  always_comb begin
    field_v = idx[1] ? min_s : sec_s;
    digits  = bcd_split(field_v);
    digit   = idx[0] ? digits[7:4] : digits[3:0];
    seg_nxt = (field_v > 6'd59) ? SEG_DASH : seg_encode(digit);
    an_nxt  = ~(4'b0001 << idx);
    dp_nxt  = (idx != 2'd2);
`ifdef ADJ_BLINK_EN
    // sel=1 targets the seconds slots (idx 0,1), sel=0 the minutes slots (idx 2,3)
    blank_nxt = bus.adj && blink_q && (bus.sel ? !idx[1] : idx[1]);
`else
    blank_nxt = 1'b0;
`endif
    if (blank_nxt) begin
      seg_nxt = SEG_OFF;
      an_nxt  = 4'hF;
      dp_nxt  = 1'b1;
    end
  end

`ifndef ADJ_BLINK_EN
  logic unused_adj_ctrl;
  assign unused_adj_ctrl = ^{bus.adj, bus.sel, blink_q};
`endif

  // Stage 1 -> 2: output register, loaded once per slot from the freshly advanced index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_p2 <= SEG_OFF;
      dp_p2  <= 1'b1;
      an_p2  <= 4'hF;
    end else if (vld_p1) begin
      seg_p2 <= seg_nxt;
      dp_p2  <= dp_nxt;
      an_p2  <= an_nxt;
    end
  end

  assign bus.seg = seg_p2;
  assign bus.dp  = dp_p2;
  assign bus.an  = an_p2;
endmodule
